// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Groups the pipeline request/response handshake and the data-memory port.
//   slave  : the load/store unit side (consumes requests, drives memory strobes)
//   master : the environment side (pipeline issuing ops plus the data memory)
// Handshake: an op transfers on a cycle where req_valid && req_ready are both 1;
// req_valid raised while req_ready=0 is simply ignored, never queued. Responses
// are a one-cycle resp_valid pulse with no back-pressure.
interface load_store_unit_if #(
    parameter int AW = 10,
    parameter int WS = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW+1:0] req_addr;
    logic [WS-1:0] req_wdata;
    logic          resp_valid;
    logic [WS-1:0] resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic [WS-1:0] mem_read_data;
    logic          mem_write_en;
    logic [WS-1:0] mem_write_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_read_en, mem_write_en, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_read_en, mem_write_en, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time between the pipeline and a
// word-addressed data memory with one-cycle read latency.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (slave) : request (valid/ready, we, size, signed, byte addr, wdata),
//                 response (valid pulse, rdata, err), memory (addr, read/write
//                 strobes, read/write data)
//   dbg_state   : current FSM state encoding
// Lanes are big-endian: byte offset 0 is bits 31:24, half offset 0 is 31:16.
// Sub-word stores are read-modify-write (RD -> MERGE -> WR).
module load_store_unit #(
    parameter int AW = 10,
    parameter int WS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DATA  = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic          we_q, signed_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [WS-1:0] wdata_q, merge_q;

    logic          accept, misaligned;
    logic [4:0]    lane_sh;
    logic [WS-1:0] lane_mask, merged, shifted, load_fmt;
    logic          rd_en, wr_en, resp_v, resp_e;
    logic [WS-1:0] resp_d;

    assign accept = bus.req_valid && bus.req_ready;

    assign misaligned = (bus.req_size == 2'b11) ||
                        (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                        (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q     <= bus.req_we;
                signed_q <= bus.req_signed;
                size_q   <= bus.req_size;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
            end
            if (state == MERGE) begin
                merge_q <= merged;
            end
        end
    end

    // Shift that moves the addressed lane down to bit 0 (big-endian offsets).
    always_comb begin
        lane_sh = 5'd0;
        case (size_q)
            2'b00:   lane_sh = {~addr_q[1:0], 3'b000};
            2'b01:   lane_sh = {~addr_q[1], 4'b0000};
            default: lane_sh = 5'd0;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   lane_mask = WS'(8'hFF) << lane_sh;
            2'b01:   lane_mask = WS'(16'hFFFF) << lane_sh;
            default: lane_mask = '1;
        endcase
    end

    assign merged  = (bus.mem_read_data & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
    assign shifted = bus.mem_read_data >> lane_sh;

    always_comb begin
        case (size_q)
            2'b00:   load_fmt = {{(WS-8){signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_fmt = {{(WS-16){signed_q & shifted[15]}}, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_comb begin
        state_nx = state;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        resp_v   = 1'b0;
        resp_e   = 1'b0;
        resp_d   = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)                state_nx = ERR;
                    else if (!bus.req_we)          state_nx = RD;
                    else if (bus.req_size == 2'b10) state_nx = WR;
                    else                           state_nx = RD;
                end
            end
            RD: begin
                rd_en    = 1'b1;
                state_nx = we_q ? MERGE : DATA;
            end
            DATA: begin
                resp_v   = 1'b1;
                resp_d   = load_fmt;
                state_nx = IDLE;
            end
            MERGE: begin
                state_nx = WR;
            end
            WR: begin
                wr_en    = 1'b1;
                resp_v   = 1'b1;
                state_nx = IDLE;
            end
            ERR: begin
                resp_v   = 1'b1;
                resp_e   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are gated by rst_n so a reset asserted mid-op (even in WR)
    // never reaches the memory or the pipeline.
    assign bus.req_ready      = rst_n && (state == IDLE);
    assign bus.resp_valid     = rst_n && resp_v;
    assign bus.resp_err       = rst_n && resp_e;
    assign bus.resp_rdata     = rst_n ? resp_d : '0;
    assign bus.mem_read_en    = rst_n && rd_en;
    assign bus.mem_write_en   = rst_n && wr_en;
    assign bus.mem_write_data = wr_en ? ((size_q == 2'b10) ? wdata_q : merge_q) : '0;
    assign bus.mem_addr       = (state != IDLE) ? addr_q[AW+1:2] : '0;
    assign dbg_state          = state;

endmodule
